// File: rtl/apb_pkg.sv
// Shared types for the APB4 memory slave: FSM state encoding and the
// helper that derives the byte-offset width from the data bus width.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of low paddr bits that select a byte within one data word.
    function automatic int unsigned byte_off_w(input int unsigned dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master and the memory slave.
// master drives psel/penable/pwrite/paddr/pwdata/pstrb; slave drives
// pready/pslverr/prdata.
interface apb4_mem_slave_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [DATA_WIDTH/8-1:0]   pstrb;
    logic                      pready;
    logic                      pslverr;
    logic [DATA_WIDTH-1:0]     prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_bytewr_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous byte-enable write, async read.
// Ports: clk, we/waddr/wdata/wstrb (write), raddr/rdata (read). No reset.
module apb_bytewr_ram #(
    parameter int unsigned DEPTH      = 48,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AW         = 6
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned SB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < SB; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 word memory slave with read-only upper region and fixed wait states.
// Ports: pclk, presetn (async active-low), bus (APB4 slave modport).
module apb4_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DEPTH       = 48,
    parameter int unsigned RO_BASE     = 40,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            pclk,
    input  logic            presetn,
    apb4_mem_slave_if.slave bus
);

    localparam int unsigned SB  = DATA_WIDTH / 8;
    localparam int unsigned OW  = byte_off_w(DATA_WIDTH);
    localparam int unsigned IW  = ADDR_WIDTH - OW;
    localparam int unsigned RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);
    localparam logic [IW:0] RO_L    = (IW+1)'(RO_BASE);
    localparam logic [3:0]  CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SB-1:0]           strb_q, strb_d;
    logic                    pready_q, pslverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    logic                    setup;
    logic                    take;
    logic                    commit;
    logic [IW-1:0]           a_idx;
    logic                    a_err;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_addr;

    // Byte-offset bits of paddr carry no meaning for a word memory.
    assign unused_addr = ^bus.paddr;

    assign setup = bus.psel & ~bus.penable;
    assign a_idx = bus.paddr[ADDR_WIDTH-1:OW];
    assign a_err = ({1'b0, a_idx} >= DEPTH_L)
                 | (bus.pwrite & ({1'b0, a_idx} >= RO_L));

    // Writes land on the edge that leaves DONE.
    assign commit = (state_q == DONE) & wr_q & ~err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: take = setup;
            WAIT: begin
                if (!bus.psel) begin
                    state_d = IDLE;
                end else if (bus.penable) begin
                    if (cnt_q == 4'd0) state_d = DONE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            DONE: begin
                take    = setup;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            idx_d   = a_idx;
            wr_d    = bus.pwrite;
            err_d   = a_err;
            wdata_d = bus.pwdata;
            strb_d  = bus.pstrb;
            if (WAIT_CYCLES > 0) begin
                state_d = WAIT;
                cnt_d   = CNT_INIT;
            end else begin
                state_d = DONE;
                cnt_d   = 4'd0;
            end
        end
    end

    // A read captured on the same edge as a pending write sees the
    // merged word so read-after-write never returns stale data.
    always_comb begin
        rd_word = ram_rdata;
        if (commit && (idx_q == idx_d)) begin
            for (int b = 0; b < SB; b++) begin
                if (strb_q[b]) rd_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= (state_d == DONE);
            pslverr_q <= (state_d == DONE) & err_d;
            if ((state_d == DONE) && !wr_d) begin
                prdata_q <= err_d ? '0 : rd_word;
            end
        end
    end

    apb_bytewr_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (RAW)
    ) u_ram (
        .clk   (pclk),
        .we    (commit),
        .waddr (idx_q[RAW-1:0]),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .raddr (idx_d[RAW-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: two instances (0 and 3 wait states) driven
// by one APB master, checked against a word/byte-level memory model.
module tb_apb4_mem_slave;

    logic pclk = 1'b0;
    logic presetn;

    always #5 pclk = ~pclk;

    apb4_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus0 ();
    apb4_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus3 ();

    logic        m_psel, m_pen, m_pwr, dsel;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;

    assign bus0.psel    = m_psel & ~dsel;
    assign bus0.penable = m_pen;
    assign bus0.pwrite  = m_pwr;
    assign bus0.paddr   = m_addr;
    assign bus0.pwdata  = m_wdata;
    assign bus0.pstrb   = m_strb;
    assign bus3.psel    = m_psel & dsel;
    assign bus3.penable = m_pen;
    assign bus3.pwrite  = m_pwr;
    assign bus3.paddr   = m_addr;
    assign bus3.pwdata  = m_wdata;
    assign bus3.pstrb   = m_strb;

    apb4_mem_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48),
        .RO_BASE(40), .WAIT_CYCLES(0)
    ) u_dut0 (
        .pclk(pclk), .presetn(presetn), .bus(bus0)
    );

    apb4_mem_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(48),
        .RO_BASE(40), .WAIT_CYCLES(3)
    ) u_dut3 (
        .pclk(pclk), .presetn(presetn), .bus(bus3)
    );

    wire        rdy_m = dsel ? bus3.pready  : bus0.pready;
    wire        err_m = dsel ? bus3.pslverr : bus0.pslverr;
    wire [31:0] prd_m = dsel ? bus3.prdata  : bus0.prdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mmem [2][64];
    logic [3:0]  mkn  [2][64];
    logic [31:0] last_rd [2];
    bit          lk [2];
    bit          exp_on = 1'b0;
    bit          exp_rdy = 1'b0;
    bit          exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Reference: word index = addr/4, 48 words, words 40.. read-only.
    task automatic model_apply(input bit d, input bit wr,
                               input logic [7:0] addr,
                               input logic [31:0] data,
                               input logic [3:0] strb,
                               output bit e);
        int idx;
        idx = int'(addr) / 4;
        e = (idx >= 48) || (wr && idx >= 40);
        if (wr) begin
            if (!e) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) begin
                        mmem[d][idx][8*b +: 8] = data[8*b +: 8];
                        mkn[d][idx][b] = 1'b1;
                    end
                end
            end
        end else if (e) begin
            last_rd[d] = 32'h0;
            lk[d] = 1'b1;
        end else begin
            last_rd[d] = mmem[d][idx];
            lk[d] = (mkn[d][idx] == 4'hF);
        end
    endtask

    always @(negedge pclk) begin
        if (exp_on) begin
            check("pready", 32'(rdy_m), 32'(exp_rdy));
            check("pslverr", 32'(err_m), 32'(exp_rdy & exp_err));
            if (lk[dsel]) check("prdata", prd_m, last_rd[dsel]);
        end
    end

    task automatic idle(input int n);
        m_psel = 1'b0;
        m_pen = 1'b0;
        exp_rdy = 1'b0;
        exp_err = 1'b0;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic xfer(input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input int abort_at, output logic [31:0] rd,
                        output bit slv, output int rdy_at,
                        output bit done);
        int w;
        bit e;
        w = dsel ? 3 : 0;
        rd = '0;
        slv = 1'b0;
        rdy_at = 0;
        done = 1'b0;
        m_psel = 1'b1;
        m_pen = 1'b0;
        m_pwr = wr;
        m_addr = addr;
        m_wdata = data;
        m_strb = strb;
        exp_rdy = 1'b0;
        exp_err = 1'b0;
        @(posedge pclk);
        #1;
        m_pen = 1'b1;
        for (int k = 1; k <= w + 1; k++) begin
            if (k > 1) begin
                @(posedge pclk);
                #1;
            end
            if (k == abort_at) begin
                m_psel = 1'b0;
                m_pen = 1'b0;
                return;
            end
            if (k == w + 1) begin
                model_apply(dsel, wr, addr, data, strb, e);
                exp_rdy = 1'b1;
                exp_err = e;
            end
            @(negedge pclk);
            if (rdy_m === 1'b1 && rdy_at == 0) rdy_at = k;
            if (k == w + 1) begin
                rd = prd_m;
                slv = err_m;
            end
        end
        @(posedge pclk);
        #1;
        exp_rdy = 1'b0;
        exp_err = 1'b0;
        done = 1'b1;
    endtask

    logic [31:0] rd;
    bit          slv, done;
    int          rat;

    task automatic wr32(input logic [7:0] a, input logic [31:0] dt,
                        input logic [3:0] s);
        xfer(1'b1, a, dt, s, -1, rd, slv, rat, done);
    endtask

    task automatic rd32(input logic [7:0] a);
        xfer(1'b0, a, 32'h0, 4'h0, -1, rd, slv, rat, done);
    endtask

    initial begin : main
        logic [5:0]  idx6;
        logic [1:0]  lo;
        int          ab;
        bit          wbit;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) begin
                mkn[d][i] = 4'h0;
                mmem[d][i] = 32'h0;
            end
        end
        presetn = 1'b0;
        dsel = 1'b0;
        m_psel = 1'b0;
        m_pen = 1'b0;
        m_pwr = 1'b0;
        m_addr = 8'h0;
        m_wdata = 32'h0;
        m_strb = 4'h0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_pready0", 32'(bus0.pready), 32'h0);
        check("rst_pslverr0", 32'(bus0.pslverr), 32'h0);
        check("rst_prdata0", bus0.prdata, 32'h0);
        check("rst_pready3", 32'(bus3.pready), 32'h0);
        check("rst_pslverr3", 32'(bus3.pslverr), 32'h0);
        check("rst_prdata3", bus3.prdata, 32'h0);
        #1;
        presetn = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        lk[0] = 1'b1;
        lk[1] = 1'b1;
        @(posedge pclk);
        #1;
        exp_on = 1'b1;
        idle(1);

        wr32(8'h04, 32'hDEADBEEF, 4'hF);
        check("w0_rdy_cycle", 32'(rat), 32'd1);
        rd32(8'h04);
        check("r0_rdy_cycle", 32'(rat), 32'd1);
        check("r0_data", rd, 32'hDEADBEEF);
        check("r0_slverr", 32'(slv), 32'h0);
        idle(1);

        wr32(8'h08, 32'hAABBCCDD, 4'hF);
        wr32(8'h08, 32'h11223344, 4'h5);
        rd32(8'h08);
        check("strb_merge", rd, 32'hAA22CC44);
        idle(1);

        wr32(8'hA0, 32'h55555555, 4'hF);
        check("ro_wr_slverr", 32'(slv), 32'h1);
        idle(1);
        rd32(8'hA0);
        check("ro_rd_slverr", 32'(slv), 32'h0);
        rd32(8'hC0);
        check("oor_rd_slverr", 32'(slv), 32'h1);
        check("oor_rd_data", rd, 32'h0);
        idle(1);

        m_psel = 1'b1;
        m_pen = 1'b1;
        m_pwr = 1'b1;
        m_addr = 8'h04;
        m_wdata = 32'h0BADF00D;
        m_strb = 4'hF;
        repeat (3) @(posedge pclk);
        #1;
        idle(1);
        rd32(8'h04);
        check("pen_no_setup", rd, 32'hDEADBEEF);
        idle(1);

        dsel = 1'b1;
        idle(1);
        wr32(8'h10, 32'h01020304, 4'hF);
        idle(1);
        rd32(8'h10);
        check("wait3_rdy_cycle", 32'(rat), 32'd4);
        check("wait3_data", rd, 32'h01020304);
        idle(1);
        xfer(1'b1, 8'h10, 32'hFFFFFFFF, 4'hF, 2, rd, slv, rat, done);
        check("abort_no_done", 32'(done), 32'h0);
        idle(1);
        rd32(8'h10);
        check("abort_old_data", rd, 32'h01020304);
        wr32(8'h14, 32'h89ABCDEF, 4'hF);
        check("b2b_w_done", 32'(done), 32'h1);
        rd32(8'h14);
        check("b2b_r_done", 32'(done), 32'h1);
        check("b2b_r_data", rd, 32'h89ABCDEF);
        idle(1);

        wr32(8'h18, 32'h12345678, 4'hF);
        idle(1);
        m_psel = 1'b1;
        m_pen = 1'b0;
        m_pwr = 1'b1;
        m_addr = 8'h18;
        m_wdata = 32'hCAFEF00D;
        m_strb = 4'hF;
        @(posedge pclk);
        #1;
        m_pen = 1'b1;
        #2;
        exp_on = 1'b0;
        presetn = 1'b0;
        #1;
        check("mid_rst_pready", 32'(bus3.pready), 32'h0);
        check("mid_rst_pslverr", 32'(bus3.pslverr), 32'h0);
        check("mid_rst_prdata", bus3.prdata, 32'h0);
        check("mid_rst_prdata0", bus0.prdata, 32'h0);
        m_psel = 1'b0;
        m_pen = 1'b0;
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        lk[0] = 1'b1;
        lk[1] = 1'b1;
        exp_on = 1'b1;
        idle(1);
        rd32(8'h18);
        check("rst_cancel_wr", rd, 32'h12345678);
        idle(1);

        for (int d = 0; d < 2; d++) begin
            dsel = d[0];
            idle(2);
            for (int i = 0; i < 150; i++) begin
                wbit = 1'($urandom_range(0, 1));
                idx6 = 6'($urandom_range(0, 63));
                lo = 2'($urandom_range(0, 3));
                ab = -1;
                if (d == 1 && $urandom_range(0, 7) == 0) begin
                    ab = int'($urandom_range(1, 3));
                end
                xfer(wbit, {idx6, lo}, $urandom, 4'($urandom),
                     ab, rd, slv, rat, done);
                if (!done || $urandom_range(0, 1) == 1) begin
                    idle(int'($urandom_range(1, 2)));
                end
            end
        end
        idle(2);
        exp_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb4_mem_slave.md
APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning PWDATA/PRDATA width; legal values 8, 16, 32, 64.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning PADDR width in byte addresses.
REQ-003 The block SHALL have parameter DEPTH, default 48, meaning implemented words; must not exceed 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 The block SHALL have parameter RO_BASE, default 40, meaning the first read-only word index; RO_BASE=DEPTH disables the read-only region.
REQ-005 The block SHALL have parameter WAIT_CYCLES, default 0, meaning the number of access cycles with pready low before completion; range 0-15.
REQ-006 The block SHALL have port pclk, input, width 1: the clock; all logic is on the rising edge.
REQ-007 The block SHALL have port presetn, input, width 1: asynchronous active-low reset.
REQ-008 The block SHALL have ports psel, penable and pwrite, each input, width 1, with APB meanings.
REQ-009 The block SHALL have port paddr, input, width ADDR_WIDTH: byte address; word index = paddr >> log2(DATA_WIDTH/8); low bits ignored.
REQ-010 The block SHALL have port pwdata, input, width DATA_WIDTH: write data.
REQ-011 The block SHALL have port pstrb, input, width DATA_WIDTH/8: write byte-lane enables.
REQ-012 The block SHALL have ports pready and pslverr, each output, width 1, registered.
REQ-013 The block SHALL have port prdata, output, width DATA_WIDTH, registered.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-015 In IDLE, psel=1 with penable=0 (setup) SHALL capture the word index, pwrite, pwdata, pstrb and the error flag at the clock edge; the FSM SHALL go to WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0, else to DONE.
REQ-016 The error flag SHALL be: index>=DEPTH; or pwrite=1 with index>=RO_BASE.
REQ-017 In WAIT, pready SHALL be 0; cnt SHALL decrement each cycle while psel&penable; at cnt=0 the FSM SHALL go to DONE.
REQ-018 Entry to DONE SHALL register pready=1 and pslverr=error flag; for reads, prdata SHALL equal mem[index], or 0 on error.
REQ-019 pready SHALL be high in exactly access cycle WAIT_CYCLES+1 after setup.
REQ-020 A write SHALL update mem only at the DONE edge, only when there is no error, and only the lanes whose pstrb bit is set; errored writes SHALL leave mem unchanged.
REQ-021 pstrb SHALL be ignored for reads.
REQ-022 After DONE, psel=1 with penable=0 (back-to-back setup) SHALL be handled as in REQ-015 with no IDLE cycle; otherwise the FSM SHALL go to IDLE.
REQ-023 pready and pslverr SHALL be 1 for DONE only and SHALL clear on the following edge.
REQ-024 prdata SHALL hold its last value until the next read completion; prdata is don't-care after writes.
REQ-025 If psel falls during WAIT (abort), the FSM SHALL go to IDLE with no mem update and no pready pulse.
REQ-026 penable=1 in IDLE without a prior setup SHALL be ignored: no state change and no write.
REQ-027 A read and a write to the same index in consecutive transfers SHALL return the new data.

Reset
REQ-028 presetn low SHALL immediately force FSM=IDLE, cnt=0, pready=0, pslverr=0 and prdata=0.
REQ-029 Reset SHALL not initialise mem; contents are undefined until written.
REQ-030 Reset asserted mid-transfer SHALL cancel the transfer with no mem update.

Structure
REQ-031 Package apb_pkg SHALL hold the state enum (IDLE/WAIT/DONE) and the function clog2-based byte-offset width.
REQ-032 Storage SHALL be a sub-module apb_bytewr_ram: DEPTH x DATA_WIDTH, synchronous byte-enable write, combinational read, no reset.

Verification
REQ-033 With WAIT_CYCLES=0, write 0xDEADBEEF to addr 0x04 with pstrb=0xF, then read 0x04: pready is high in the first access cycle, prdata=0xDEADBEEF, and pslverr=0.
REQ-034 Write 0xAABBCCDD to 0x08 with pstrb=0xF, then write 0x11223344 to 0x08 with pstrb=0x5, then read 0x08: prdata=0xAA22CC44.
REQ-035 With WAIT_CYCLES=3, a read takes 3 access cycles with pready=0 followed by pready=1 on the 4th.
REQ-036 Write to word 40 (addr 0xA0) gets pslverr=1 and the data is unchanged; a read of 0xA0 gets pslverr=0; a read of word 48 (0xC0) gets pslverr=1 and prdata=0.
REQ-037 Drop psel during WAIT then read the same address: the old data is returned; back-to-back transfers with no IDLE cycle both complete.
REQ-038 Assert presetn low during WAIT: outputs are 0 immediately and a following read shows the write did not occur.
